wb_mprj_splitter: RTL and testbench

WB_MPRJ_SPLITTER -- requirements
Module: wb_mprj_splitter

---
 rtl/wb_mprj_pkg.sv | 17 +
 rtl/wb_mprj_addr_decode.sv | 27 ++
 rtl/wb_mprj_splitter.sv | 153 +++++++++++++++
 tb/tb_wb_mprj_splitter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mprj_pkg.sv
// Shared types and constants for the Wishbone user-project splitter.
package wb_mprj_pkg;

    // At most 8 slaves, so a slot index always fits in 3 bits.
    localparam int unsigned SLOT_W     = 3;
    localparam int unsigned MAX_SLAVES = 8;

    localparam logic [31:0] MISS_DATA     = 32'hBADD_ADD0;
    localparam logic [31:0] TMO_DATA_BASE = 32'hDEAD_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

endpackage

// File: rtl/wb_mprj_addr_decode.sv
// Address window decode: host address -> hit flag and slave slot index.
module wb_mprj_addr_decode
    import wb_mprj_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned SLOT_AW    = 16
) (
    input  logic [31:0]       adr,
    output logic              hit,
    output logic [SLOT_W-1:0] slot
);

    // Window size held in 33 bits so a window touching the top of the
    // address space cannot wrap.
    localparam logic [32:0] WIN_SIZE = 33'(NUM_SLAVES) << SLOT_AW;

    logic [31:0] offset;

    // Offset from the window base; slot is the offset in whole slot units.
    always_comb begin
        offset = adr - BASE_ADDR;
        hit    = (adr >= BASE_ADDR) && ({1'b0, offset} < WIN_SIZE);
        slot   = SLOT_W'(offset >> SLOT_AW);
    end

endmodule

// File: rtl/wb_mprj_splitter.sv
// Wishbone classic 1-to-NUM_SLAVES splitter for the user project area.
// Optional slave-ack timeout with interrupt: define WB_MPRJ_TIMEOUT_EN.
module wb_mprj_splitter
    import wb_mprj_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int unsigned SLOT_AW        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    output logic [NUM_SLAVES-1:0]      m_cyc_o,
    output logic [NUM_SLAVES-1:0]      m_stb_o,
    output logic                       m_we_o,
    output logic [3:0]                 m_sel_o,
    output logic [31:0]                m_adr_o,
    output logic [31:0]                m_dat_o,
    input  logic [NUM_SLAVES-1:0]      m_ack_i,
    input  logic [32*NUM_SLAVES-1:0]   m_dat_i,
    output logic                       irq_o
);

    state_t                 state_q, state_d;
    logic [SLOT_W-1:0]      slot_q;
    logic [NUM_SLAVES-1:0]  strb_q;
    logic                   req;
    logic                   dec_hit;
    logic [SLOT_W-1:0]      dec_slot;
    logic                   slave_ack;
    logic                   tmo_fire;
    logic [MAX_SLAVES-1:0]  ack_ext;
    logic [MAX_SLAVES-1:0]  strb_onehot;
    logic [32*MAX_SLAVES-1:0] dat_ext;

    // Ack is registered and lands while the FSM is back in IDLE, so the
    // !wbs_ack_o term is what blocks re-accepting the same request.
    assign req         = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign ack_ext     = MAX_SLAVES'(m_ack_i);
    assign dat_ext     = (32*MAX_SLAVES)'(m_dat_i);
    assign slave_ack   = ack_ext[slot_q];
    assign strb_onehot = MAX_SLAVES'(1) << dec_slot;
    assign m_cyc_o     = strb_q;
    assign m_stb_o     = strb_q;

    wb_mprj_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR),
        .SLOT_AW    (SLOT_AW)
    ) u_decode (
        .adr  (wbs_adr_i),
        .hit  (dec_hit),
        .slot (dec_slot)
    );

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next-state: host abort beats slave ack, slave ack beats timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req) state_d = dec_hit ? ST_BUSY : ST_RESP;
            ST_BUSY: begin
                if (!wbs_cyc_i)                  state_d = ST_IDLE;
                else if (slave_ack || tmo_fire)  state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered request fields, slave strobes, host ack and read data.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            slot_q    <= '0;
            strb_q    <= '0;
            m_we_o    <= 1'b0;
            m_sel_o   <= '0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            unique case (state_q)
                ST_IDLE: if (req) begin
                    m_we_o  <= wbs_we_i;
                    m_sel_o <= wbs_sel_i;
                    m_adr_o <= wbs_adr_i;
                    m_dat_o <= wbs_dat_i;
                    slot_q  <= dec_slot;
                    if (dec_hit) strb_q    <= strb_onehot[NUM_SLAVES-1:0];
                    else         wbs_dat_o <= MISS_DATA;
                end
                ST_BUSY: begin
                    if (!wbs_cyc_i) begin
                        strb_q <= '0;
                    end else if (slave_ack) begin
                        strb_q    <= '0;
                        wbs_dat_o <= m_we_o ? '0 : dat_ext[{slot_q, 5'b0} +: 32];
                    end else if (tmo_fire) begin
                        strb_q    <= '0;
                        wbs_dat_o <= TMO_DATA_BASE | 32'(slot_q);
                    end
                end
                ST_RESP: wbs_ack_o <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef WB_MPRJ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;

    // Fires on the BUSY cycle whose count step would reach TIMEOUT_CYCLES.
    assign tmo_fire = (tmo_cnt == TMO_LAST);

    // Counter restarts outside BUSY; irq pulses only when the timeout wins.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_cnt <= '0;
            irq_o   <= 1'b0;
        end else begin
            irq_o <= (state_q == ST_BUSY) && wbs_cyc_i && !slave_ack && tmo_fire;
            if (state_q != ST_BUSY) tmo_cnt <= '0;
            else                    tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign irq_o    = 1'b0;

    // TIMEOUT_CYCLES only matters with the timeout built in; this empty
    // block keeps it referenced in the default build.
    if (TIMEOUT_CYCLES == 0) begin : g_tmo_unused
    end
`endif

endmodule

// File: tb/tb_wb_mprj_splitter.sv
// Self-checking bench for wb_mprj_splitter: host driver, slave models and
// a scoreboard of expected host responses compared when wbs_ack_o arrives.
module tb_wb_mprj_splitter;

    localparam int unsigned NS   = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int unsigned AW   = 16;
`ifdef WB_MPRJ_TIMEOUT_EN
    localparam int unsigned TMO  = 8;
`else
    localparam int unsigned TMO  = 255;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cyc, stb, we;
    logic [3:0]         sel;
    logic [31:0]        adr, wdat;
    logic               ack;
    logic [31:0]        rdat;
    logic [NS-1:0]      m_cyc, m_stb;
    logic               m_we;
    logic [3:0]         m_sel;
    logic [31:0]        m_adr, m_dat;
    logic [NS-1:0]      m_ack;
    logic [32*NS-1:0]   m_rdat;
    logic               irq;

    wb_mprj_splitter #(
        .NUM_SLAVES     (NS),
        .BASE_ADDR      (BASE),
        .SLOT_AW        (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i  (clk),    .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),    .wbs_stb_i (stb),    .wbs_we_i (we),
        .wbs_sel_i (sel),    .wbs_adr_i (adr),    .wbs_dat_i (wdat),
        .wbs_ack_o (ack),    .wbs_dat_o (rdat),
        .m_cyc_o   (m_cyc),  .m_stb_o   (m_stb),  .m_we_o   (m_we),
        .m_sel_o   (m_sel),  .m_adr_o   (m_adr),  .m_dat_o  (m_dat),
        .m_ack_i   (m_ack),  .m_dat_i   (m_rdat), .irq_o    (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard entry: expected read data and whether irq precedes the ack.
    typedef struct packed {
        logic [31:0] dat;
        logic        irq;
    } resp_t;
    resp_t sb_q[$];

    // Slave models: per-slave enable, ack delay, read data, and a "spam"
    // mode that holds ack high regardless of strobe.
    logic [NS-1:0] slv_en   = '1;
    logic [NS-1:0] slv_spam = '0;
    int            slv_dly [NS];
    logic [31:0]   slv_rd  [NS];

    initial begin
        int wcnt [NS];
        for (int k = 0; k < NS; k++) begin
            wcnt[k] = 0; slv_dly[k] = 0; slv_rd[k] = 32'h1000_0000 + 32'(k);
        end
        m_ack = '0; m_rdat = '1;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < NS; k++) begin
                m_ack[k] = slv_spam[k];
                m_rdat[32*k +: 32] = 32'hFFFF_FFFF;
                if (m_stb[k] && slv_en[k] && !slv_spam[k]) begin
                    if (wcnt[k] >= slv_dly[k]) begin
                        m_ack[k] = 1'b1;
                        m_rdat[32*k +: 32] = slv_rd[k];
                        wcnt[k] = 0;
                    end else begin
                        wcnt[k]++;
                    end
                end else begin
                    wcnt[k] = 0;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each ack; also checks the
    // ack is a single-cycle pulse and that irq preceded it only when expected.
    initial begin
        logic prev_ack = 1'b0;
        logic irq_seen = 1'b0;
        resp_t r;
        forever begin
            @(posedge clk); #1;
            if (irq) irq_seen = 1'b1;
            if (prev_ack) check("ack_one_cycle", 32'(ack), 32'd0);
            if (ack && !prev_ack) begin
                if (sb_q.size() == 0) begin
                    check("spurious_ack", 32'(ack), 32'd0);
                end else begin
                    r = sb_q.pop_front();
                    check("ack_data", rdat, r.dat);
                    check("irq_pulse", 32'(irq_seen), 32'(r.irq));
                end
                irq_seen = 1'b0;
            end
            prev_ack = ack;
        end
    end

    function automatic logic model_hit(input logic [31:0] a);
        longint unsigned off = longint'(a) - longint'(BASE);
        return (a >= BASE) && (off < (longint'(NS) << AW));
    endfunction

    function automatic int model_slot(input logic [31:0] a);
        return int'((a - BASE) >> AW);
    endfunction

    task automatic idle(input int n);
        cyc = 1'b0; stb = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One host transfer: inputs change now, then wait (bounded) for ack.
    // exp_lat < 0 skips the latency check.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input int exp_lat);
        logic          hit   = model_hit(a);
        int            slot  = model_slot(a);
        logic [NS-1:0] exp_oh = hit ? NS'(1) << slot : '0;
        logic [NS-1:0] stb_or = '0, cyc_or = '0;
        resp_t         r;
        int            n = 0;
        r.irq = 1'b0;
        if (!hit)               r.dat = 32'hBADD_ADD0;
        else if (!slv_en[slot]) begin r.dat = 32'hDEAD_0000 | 32'(slot); r.irq = 1'b1; end
        else                    r.dat = w ? 32'h0 : slv_rd[slot];
        sb_q.push_back(r);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        do begin
            @(posedge clk); #1;
            n++;
            stb_or |= m_stb; cyc_or |= m_cyc;
        end while (!ack && n < 100);
        check("ack_timeout", 32'(ack), 32'd1);
        if (exp_lat >= 0) check("ack_latency", 32'(n), 32'(exp_lat));
        check("m_stb", 32'(stb_or), 32'(exp_oh));
        check("m_cyc", 32'(cyc_or), 32'(exp_oh));
        check("m_adr", m_adr, a);
        check("m_we",  32'(m_we), 32'(w));
        check("m_sel", 32'(m_sel), 32'(s));
        check("m_dat", m_dat, d);
    endtask

    // Start a read to a silent slave and let it sit in BUSY for a few cycles.
    task automatic start_stall(input logic [31:0] a);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; wdat = '0; sel = 4'hF;
        repeat (3) begin @(posedge clk); #1; end
        check("stall_stb", 32'(m_stb), 32'(NS'(1) << model_slot(a)));
    endtask

    initial begin
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        rst_n = 1'b0;
        #23;
        check("rst_ack",   32'(ack), 0);
        check("rst_rdat",  rdat, 0);
        check("rst_stb",   32'(m_stb), 0);
        check("rst_cyc",   32'(m_cyc), 0);
        check("rst_madr",  m_adr, 0);
        check("rst_mdat",  m_dat, 0);
        check("rst_msel",  32'(m_sel), 0);
        check("rst_mwe",   32'(m_we), 0);
        check("rst_irq",   32'(irq), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Slave 1 read, 1-cycle ack delay.
        slv_dly[1] = 1; slv_rd[1] = 32'h1234_5678;
        xfer(32'h3001_0004, 1'b0, 32'h0, 4'hF, 4);
        idle(1);
        // Write to slave 0, zero-wait ack.
        xfer(32'h3000_0000, 1'b1, 32'hA5A5_A5A5, 4'b0011, 3);
        idle(1);
        // Miss above the window: minimum latency, no strobe.
        xfer(32'h4000_0000, 1'b0, 32'h0, 4'hF, 2);
        idle(1);
        // Window edges: last word of slot 3, first word past it, word below base.
        slv_rd[3] = 32'hCAFE_0003;
        xfer(32'h3003_FFFC, 1'b0, 32'h0, 4'hF, 3);
        idle(1);
        xfer(32'h3004_0000, 1'b0, 32'h0, 4'hF, 2);
        idle(1);
        xfer(32'h2FFF_FFFC, 1'b0, 32'h0, 4'hF, 2);
        // Back-to-back: request held straight after the ack sees a 1-cycle gap.
        xfer(32'h5000_0000, 1'b1, 32'h1, 4'h1, 3);
        idle(1);
        // Another slave holding ack high must not complete a slot-1 read.
        slv_spam[3] = 1'b1; slv_dly[1] = 3; slv_rd[1] = 32'h0BAD_F00D;
        xfer(32'h3001_0100, 1'b0, 32'h0, 4'hF, 6);
        slv_spam[3] = 1'b0;
        idle(1);

        // Mixed random traffic over hits and misses.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            for (int k = 0; k < NS; k++) begin
                slv_dly[k] = int'($urandom_range(0, 3));
                slv_rd[k]  = $urandom;
            end
            a = BASE + (32'($urandom_range(0, 5)) << AW) + ($urandom & 32'h0000_FFFC);
            xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), -1);
            idle(int'($urandom_range(0, 2)));
        end
        idle(1);

        // Host drops cyc while slave 2 is stalled: strobes fall, no ack.
        slv_en[2] = 1'b0;
        start_stall(32'h3002_0008);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("abort_stb", 32'(m_stb), 0);
        check("abort_cyc", 32'(m_cyc), 0);
        idle(4);
        check("abort_noack_sb", 32'(sb_q.size()), 0);

        // Reset pulsed mid-BUSY: immediate abort, no ack.
        start_stall(32'h3002_0010);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_stb", 32'(m_stb), 0);
        check("rstmid_ack", 32'(ack), 0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        slv_en[2] = 1'b1; slv_dly[2] = 0; slv_rd[2] = 32'h2222_2222;
        xfer(32'h3002_0010, 1'b0, 32'h0, 4'hF, 3);
        idle(2);

`ifdef WB_MPRJ_TIMEOUT_EN
        // Silent slave 2: timeout data and irq pulse.
        slv_en[2] = 1'b0;
        xfer(32'h3002_0000, 1'b0, 32'h0, 4'hF, TMO + 2);
        idle(2);
        // Ack in the cycle the timeout would fire: normal data, no irq.
        slv_en[2] = 1'b1; slv_dly[2] = TMO - 1; slv_rd[2] = 32'h5A5A_0002;
        xfer(32'h3002_0004, 1'b0, 32'h0, 4'hF, TMO + 2);
        idle(2);
`endif

        check("sb_drained", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute backstop against a hung run.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
